// File: rtl/sprite_line_buffer_banked_if.sv
// Bus bundle for sprite_line_buffer_banked: swap handshake, renderer and composer ports.
// master = renderer/composer side, slave = the line buffer.
interface sprite_line_buffer_banked_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 10
);
  logic                  swap_req;
  logic                  swap_ack;
  logic                  render_buf;
  logic [IDX_W-1:0]      renderer_rd_idx;
  logic [DATA_WIDTH-1:0] renderer_rd_data;
  logic [IDX_W-1:0]      renderer_wr_idx;
  logic [DATA_WIDTH-1:0] renderer_wr_data;
  logic                  renderer_wr_en;
  logic [IDX_W-1:0]      composer_rd_idx;
  logic [DATA_WIDTH-1:0] composer_rd_data;
  logic                  composer_erase_start;
  logic                  composer_erase_busy;
  logic                  erase_state_dbg;

  modport master (
    output swap_req, renderer_rd_idx, renderer_wr_idx, renderer_wr_data, renderer_wr_en,
           composer_rd_idx, composer_erase_start,
    input  swap_ack, render_buf, renderer_rd_data, composer_rd_data, composer_erase_busy,
           erase_state_dbg
  );

  modport slave (
    input  swap_req, renderer_rd_idx, renderer_wr_idx, renderer_wr_data, renderer_wr_en,
           composer_rd_idx, composer_erase_start,
    output swap_ack, render_buf, renderer_rd_data, composer_rd_data, composer_erase_busy,
           erase_state_dbg
  );
endinterface

// File: rtl/sprite_line_buffer_banked.sv
// Double-buffered, bank-interleaved sprite line buffer with swap handshake and erase engine.
// Optional macro SPRITE_LB_TRANSPARENT_SKIP_EN: drop renderer writes whose data equals ERASE_VALUE.
module sprite_line_buffer_banked #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    LINE_LEN    = 640,
  parameter int                    BANKS       = 4,
  parameter logic [DATA_WIDTH-1:0] ERASE_VALUE = '0,
  parameter int                    IDX_W       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sprite_line_buffer_banked_if.slave bus
);
  localparam int DEPTH  = LINE_LEN / BANKS;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int WORD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]    LINE_LEN_L = (IDX_W+1)'(LINE_LEN);
  localparam logic [IDX_W-1:0]  BANKS_L    = IDX_W'(BANKS);
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(DEPTH - 1);

  typedef enum logic {ERASE_IDLE, ERASE_BUSY} erase_state_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < LINE_LEN_L;
  endfunction
  function automatic logic [BANK_W-1:0] bank_of(input logic [IDX_W-1:0] idx);
    return BANK_W'(idx % BANKS_L);
  endfunction
  // Out-of-range indices map to word 0 so the array is never addressed past its end.
  function automatic logic [WORD_W-1:0] word_of(input logic [IDX_W-1:0] idx);
    return in_range(idx) ? WORD_W'(idx / BANKS_L) : '0;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2][BANKS][DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_q [BANKS];
  logic [DATA_WIDTH-1:0] c_rd_q [BANKS];
  logic [BANK_W-1:0]     r_bank_q, c_bank_q;
  logic                  r_in_q, c_in_q;

  erase_state_t      state, state_nxt;
  logic [WORD_W-1:0] erase_cnt, erase_cnt_nxt;
  logic              erase_buf;
  logic              erase_busy;
  logic              render_buf_q, swap_ack_q, swap_pending, swap_fire;
  logic              wr_ok;

  // Swap handshake: swap_req is a single-cycle request captured into swap_pending
  // (repeats while pending are absorbed); swap_ack is a single-cycle pulse in the
  // same cycle render_buf first shows the new owner. No erase may be running.
  assign erase_busy = (state == ERASE_BUSY);
  assign swap_fire  = (swap_pending | bus.swap_req) & ~erase_busy & ~bus.composer_erase_start;

`ifdef SPRITE_LB_TRANSPARENT_SKIP_EN
  assign wr_ok = bus.renderer_wr_en & in_range(bus.renderer_wr_idx)
               & (bus.renderer_wr_data != ERASE_VALUE);
`else
  assign wr_ok = bus.renderer_wr_en & in_range(bus.renderer_wr_idx);
`endif

  always_comb begin
    state_nxt     = state;
    erase_cnt_nxt = erase_cnt;
    case (state)
      ERASE_IDLE: begin
        if (bus.composer_erase_start) begin
          state_nxt     = ERASE_BUSY;
          erase_cnt_nxt = '0;
        end
      end
      ERASE_BUSY: begin
        if (bus.composer_erase_start) erase_cnt_nxt = '0;
        else if (erase_cnt == LAST_WORD) state_nxt = ERASE_IDLE;
        else erase_cnt_nxt = erase_cnt + 1'b1;
      end
      default: state_nxt = ERASE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ERASE_IDLE;
      erase_cnt    <= '0;
      erase_buf    <= 1'b0;
      render_buf_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      swap_pending <= 1'b0;
      r_bank_q     <= '0;
      c_bank_q     <= '0;
      r_in_q       <= 1'b0;
      c_in_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      erase_cnt    <= erase_cnt_nxt;
      // During the ack cycle render_buf already flipped, so the pre-swap composer buffer is render_buf.
      if (bus.composer_erase_start) erase_buf <= swap_ack_q ? render_buf_q : ~render_buf_q;
      swap_ack_q   <= swap_fire;
      swap_pending <= swap_fire ? 1'b0 : (swap_pending | bus.swap_req);
      if (swap_fire) render_buf_q <= ~render_buf_q;
      r_bank_q     <= bank_of(bus.renderer_rd_idx);
      c_bank_q     <= bank_of(bus.composer_rd_idx);
      r_in_q       <= in_range(bus.renderer_rd_idx);
      c_in_q       <= in_range(bus.composer_rd_idx);
    end
  end

  // Storage and read registers: erase writes follow renderer writes, so erase wins a collision.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      r_rd_q[b] <= mem[render_buf_q][b][word_of(bus.renderer_rd_idx)];
      c_rd_q[b] <= mem[~render_buf_q][b][word_of(bus.composer_rd_idx)];
    end
    if (wr_ok)
      mem[render_buf_q][bank_of(bus.renderer_wr_idx)][word_of(bus.renderer_wr_idx)] <= bus.renderer_wr_data;
    if (erase_busy)
      for (int b = 0; b < BANKS; b++) mem[erase_buf][b][erase_cnt] <= ERASE_VALUE;
  end

  assign bus.renderer_rd_data    = r_in_q ? r_rd_q[r_bank_q] : ERASE_VALUE;
  assign bus.composer_rd_data    = c_in_q ? c_rd_q[c_bank_q] : ERASE_VALUE;
  assign bus.swap_ack            = swap_ack_q;
  assign bus.render_buf          = render_buf_q;
  assign bus.composer_erase_busy = erase_busy;
  assign bus.erase_state_dbg     = logic'(state);
endmodule

// File: tb/tb_sprite_line_buffer_banked.sv
// Directed bench for sprite_line_buffer_banked: read expectations go into per-port queues,
// a monitor pops them one cycle after each issued read; control outputs are checked inline.
module tb_sprite_line_buffer_banked;
  localparam int W  = 16;
  localparam int IW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_line_buffer_banked_if #(.DATA_WIDTH(W), .IDX_W(IW)) bus ();

  sprite_line_buffer_banked #(
    .DATA_WIDTH(W), .LINE_LEN(640), .BANKS(4), .ERASE_VALUE(16'h0000), .IDX_W(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_r_q[$];
  logic [W-1:0] exp_c_q[$];
  logic issue_r = 1'b0, issue_c = 1'b0;
  logic mon_r = 1'b0, mon_c = 1'b0;
  int n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read data is valid one cycle after the read was issued.
  always @(posedge clk) begin
    mon_r <= issue_r;
    mon_c <= issue_c;
  end

  always @(negedge clk) begin
    if (mon_r) begin
      if (exp_r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rend_rd: got %0h with no expected value queued", bus.renderer_rd_data);
      end else check("rend_rd", bus.renderer_rd_data, exp_r_q.pop_front());
    end
    if (mon_c) begin
      if (exp_c_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL comp_rd: got %0h with no expected value queued", bus.composer_rd_data);
      end else check("comp_rd", bus.composer_rd_data, exp_c_q.pop_front());
    end
  end

  // Driver tasks: entered at a negedge, each consumes exactly one cycle.
  task automatic wr(input logic [IW-1:0] idx, input logic [W-1:0] d);
    bus.renderer_wr_idx  = idx;
    bus.renderer_wr_data = d;
    bus.renderer_wr_en   = 1'b1;
    @(negedge clk);
    bus.renderer_wr_en   = 1'b0;
  endtask

  task automatic rd_r(input logic [IW-1:0] idx, input logic [W-1:0] exp);
    bus.renderer_rd_idx = idx;
    exp_r_q.push_back(exp);
    issue_r = 1'b1;
    @(negedge clk);
    issue_r = 1'b0;
  endtask

  task automatic rd_c(input logic [IW-1:0] idx, input logic [W-1:0] exp);
    bus.composer_rd_idx = idx;
    exp_c_q.push_back(exp);
    issue_c = 1'b1;
    @(negedge clk);
    issue_c = 1'b0;
  endtask

  task automatic rw_r(input logic [IW-1:0] ridx, input logic [W-1:0] exp,
                      input logic [IW-1:0] widx, input logic [W-1:0] d);
    bus.renderer_wr_idx  = widx;
    bus.renderer_wr_data = d;
    bus.renderer_wr_en   = 1'b1;
    bus.renderer_rd_idx  = ridx;
    exp_r_q.push_back(exp);
    issue_r = 1'b1;
    @(negedge clk);
    issue_r = 1'b0;
    bus.renderer_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.swap_req = 1'b0;
    bus.renderer_rd_idx = '0;
    bus.renderer_wr_idx = '0;
    bus.renderer_wr_data = '0;
    bus.renderer_wr_en = 1'b0;
    bus.composer_rd_idx = '0;
    bus.composer_erase_start = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_render_buf", bus.render_buf, 0);
    check("rst_busy", bus.composer_erase_busy, 0);
    check("rst_swap_ack", bus.swap_ack, 0);
    check("rst_comp_data", bus.composer_rd_data, 16'h0000);
    check("rst_rend_data", bus.renderer_rd_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    rd_c(10'd640, 16'h0000);

    // Fill idx 0..7 (two words across all four banks) and read back
    for (int i = 0; i < 8; i++) wr(IW'(i), 16'h0100 + W'(i));
    rd_r(10'd5, 16'h0105);
    for (int i = 0; i < 8; i++) rd_r(IW'(i), 16'h0100 + W'(i));

    // Swap with no erase: ack and new owner one cycle after the request
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
    check("swap_ack_pulse", bus.swap_ack, 1);
    check("render_buf_after_swap", bus.render_buf, 1);
    rd_c(10'd5, 16'h0105);
    check("swap_ack_one_cycle", bus.swap_ack, 0);

    // Erase buffer 0 (composer side); renderer writes buffer 1 meanwhile
    bus.composer_erase_start = 1'b1;
    @(negedge clk);
    bus.composer_erase_start = 1'b0;
    n = 0;
    while (bus.composer_erase_busy && n < 400) begin
      n++;
      if (n == 1) begin
        bus.composer_rd_idx = 10'd7;
        exp_c_q.push_back(16'h0107);
        issue_c = 1'b1;
      end
      if (n == 2) begin
        bus.renderer_wr_idx  = 10'd20;
        bus.renderer_wr_data = 16'h2020;
        bus.renderer_wr_en   = 1'b1;
      end
      if (n == 10 || n == 20) bus.swap_req = 1'b1;
      if (n > 1 && bus.swap_ack) check("no_ack_during_erase", bus.swap_ack, 0);
      @(negedge clk);
      issue_c = 1'b0;
      bus.swap_req = 1'b0;
      bus.renderer_wr_en = 1'b0;
    end
    check("erase_busy_cycles", n, 160);
    check("ack_not_yet", bus.swap_ack, 0);
    check("render_buf_pre_swap", bus.render_buf, 1);
    @(negedge clk);
    check("ack_after_busy", bus.swap_ack, 1);
    check("render_buf_post_erase_swap", bus.render_buf, 0);
    @(negedge clk);
    check("ack_single", bus.swap_ack, 0);
    check("render_buf_single_swap", bus.render_buf, 0);

    // Erased buffer is now the renderer's; buffer 1 is the composer's
    for (int i = 0; i < 640; i++) rd_r(IW'(i), 16'h0000);
    rd_c(10'd20, 16'h2020);

    // Out-of-range write is dropped, out-of-range read returns the erase value
    wr(10'd640, 16'hBEEF);
    rd_r(10'd640, 16'h0000);
    rd_r(10'd0, 16'h0000);
    rd_r(10'd1023, 16'h0000);

    // Same-cycle read/write returns old data
    wr(10'd3, 16'h0333);
    rw_r(10'd3, 16'h0333, 10'd3, 16'h0444);
    rd_r(10'd3, 16'h0444);

    // Transparent pixel write
    wr(10'd9, 16'h0042);
    wr(10'd9, 16'h0000);
`ifdef SPRITE_LB_TRANSPARENT_SKIP_EN
    rd_r(10'd9, 16'h0042);
`else
    rd_r(10'd9, 16'h0000);
`endif

    // Asynchronous reset during an erase clears busy at once
    bus.composer_erase_start = 1'b1;
    @(negedge clk);
    bus.composer_erase_start = 1'b0;
    @(negedge clk);
    check("busy_before_reset", bus.composer_erase_busy, 1);
    rst_n = 1'b0;
    #1;
    check("busy_cleared_by_reset", bus.composer_erase_busy, 0);
    check("render_buf_reset", bus.render_buf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("queues_drained", exp_r_q.size() + exp_c_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
